// File: rtl/imem_loader.sv
// Boot loader: frames of UART bytes -> 32-bit instruction RAM writes, CPU held until a clean image.
// Optional byte echo to a UART transmitter when LOADER_ECHO_EN is defined.
module imem_loader #(
   parameter int          DEPTH   = 128,
   parameter int          TIMEOUT = 1000000,
   parameter logic [7:0]  HEADER  = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
`ifdef LOADER_ECHO_EN
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
`endif
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);
   localparam int IW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, WORD, CSUM, DONE, ERR} state_t;

   state_t         state;
   logic [7:0]     cnt_hi;
   logic [15:0]    n_words;
   logic [15:0]    n_cur;
   logic [IW-1:0]  idx;
   logic [1:0]     bidx;
   logic [7:0]     acc;
   logic [TW-1:0]  tmo;
   logic           framing;

   assign n_cur   = {cnt_hi, rx_data};
   assign framing = (state == CNT_HI) || (state == CNT_LO) || (state == WORD) || (state == CSUM);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt_hi   <= '0;
         n_words  <= '0;
         idx      <= '0;
         bidx     <= '0;
         acc      <= '0;
         tmo      <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         cpu_hold <= 1'b1;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         // silence counter only runs inside a frame; any byte restarts it
         if (rx_valid || !framing) tmo <= '0;
         else                      tmo <= tmo + TW'(1);

         if (rx_valid) begin
            case (state)
               IDLE, DONE, ERR: begin
                  if (rx_data == HEADER) begin
                     state    <= CNT_HI;
                     cpu_hold <= 1'b1;
                     done     <= 1'b0;
                     error    <= 1'b0;
                     idx      <= '0;
                     bidx     <= '0;
                     acc      <= '0;
                  end
               end
               CNT_HI: begin
                  cnt_hi <= rx_data;
                  state  <= CNT_LO;
               end
               CNT_LO: begin
                  n_words <= n_cur;
                  if (32'(n_cur) > DEPTH) begin
                     state <= ERR;
                     error <= 1'b1;
                  end else if (n_cur == 16'd0) begin
                     state <= CSUM;
                  end else begin
                     state <= WORD;
                  end
               end
               WORD: begin
                  wr_data <= {wr_data[23:0], rx_data};
                  acc     <= acc ^ rx_data;
                  bidx    <= bidx + 2'd1;
                  if (bidx == 2'd3) begin
                     wr_en   <= 1'b1;
                     wr_addr <= 32'(idx) << 2;
                     idx     <= idx + IW'(1);
                     if (32'(idx) + 32'd1 == 32'(n_words)) state <= CSUM;
                  end
               end
               CSUM: begin
                  if (rx_data == acc) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (framing && tmo == TW'(TIMEOUT - 1)) begin
            state <= ERR;
            error <= 1'b1;
         end
      end
   end

`ifdef LOADER_ECHO_EN
   logic [7:0] echo_buf;
   logic       echo_full;

   // single-entry buffer: bytes arriving while it is occupied are dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         echo_buf  <= '0;
         echo_full <= 1'b0;
         tx_data   <= '0;
         tx_start  <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         if (echo_full) begin
            if (!tx_busy) begin
               tx_start  <= 1'b1;
               tx_data   <= echo_buf;
               echo_full <= 1'b0;
            end
         end else if (rx_valid) begin
            echo_buf  <= rx_data;
            echo_full <= 1'b1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame stimulus checked cycle-by-cycle against a frame-position model,
// plus literal expectations from hand-worked frames.
module tb_imem_loader;
   localparam int         DEPTH = 128;
   localparam int         TMO   = 40;
   localparam logic [7:0] HDR   = 8'hA5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        wr_en, cpu_hold, done, error;
   logic [31:0] wr_addr, wr_data;
`ifdef LOADER_ECHO_EN
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy = 1'b0;
`endif

   imem_loader #(.DEPTH(DEPTH), .TIMEOUT(TMO), .HEADER(HDR)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
`ifdef LOADER_ECHO_EN
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
`endif
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: position within the current frame
   bit          m_in_frame;
   int          m_pos, m_n, m_silent, m_wr_cnt;
   logic [7:0]  m_acc, m_nhi;
   logic [31:0] m_word;
   logic        m_wr_en, m_hold, m_done, m_err;
   logic [31:0] m_wr_addr, m_wr_data;
   logic [31:0] m_ram [DEPTH];
   logic [31:0] d_ram [DEPTH];
   int          d_wr_cnt = 0;

   initial for (int i = 0; i < DEPTH; i++) begin m_ram[i] = 0; d_ram[i] = 0; end

   always @(posedge clk) begin
      m_wr_en = 1'b0;
      if (reset) begin
         m_in_frame = 0; m_silent = 0;
         m_wr_addr = 0; m_wr_data = 0; m_hold = 1; m_done = 0; m_err = 0;
      end else if (rx_valid) begin
         m_silent = 0;
         if (!m_in_frame) begin
            if (rx_data == HDR) begin
               m_in_frame = 1; m_pos = 1; m_acc = 0;
               m_hold = 1; m_done = 0; m_err = 0;
            end
         end else begin
            if (m_pos == 1) m_nhi = rx_data;
            else if (m_pos == 2) begin
               m_n = {m_nhi, rx_data};
               if (m_n > DEPTH) begin m_err = 1; m_in_frame = 0; end
            end else if (m_pos < 3 + 4 * m_n) begin
               m_acc ^= rx_data;
               m_word = {m_word[23:0], rx_data};
               if ((m_pos - 3) % 4 == 3) begin
                  m_wr_en = 1;
                  m_wr_addr = ((m_pos - 3) / 4) * 4;
                  m_wr_data = m_word;
                  m_ram[(m_pos - 3) / 4] = m_word;
                  m_wr_cnt++;
               end
            end else begin
               if (rx_data == m_acc) begin m_done = 1; m_hold = 0; end
               else m_err = 1;
               m_in_frame = 0;
            end
            m_pos++;
         end
      end else if (m_in_frame) begin
         m_silent++;
         if (m_silent == TMO) begin m_err = 1; m_in_frame = 0; end
      end
   end

   // ---------------- compare process
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         d_wr_cnt++;
         d_ram[wr_addr[8:2]] = wr_data;
      end
      if (cmp_en) begin
         chk("wr_en", {31'd0, wr_en}, {31'd0, m_wr_en});
         chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, m_hold});
         chk("done", {31'd0, done}, {31'd0, m_done});
         chk("error", {31'd0, error}, {31'd0, m_err});
         if (m_wr_en) begin
            chk("wr_addr", wr_addr, m_wr_addr);
            chk("wr_data", wr_data, m_wr_data);
         end
      end
   end

   // ---------------- stimulus
   task automatic put(input logic [7:0] b);
      @(posedge clk); #2; rx_valid = 1'b1; rx_data = b;
   endtask

   task automatic gap(input int n);
      repeat (n) begin @(posedge clk); #2; rx_valid = 1'b0; rx_data = 8'($urandom); end
   endtask

   task automatic send_frame(input int n, input bit bad, input int maxgap);
      logic [7:0] acc, b;
      acc = 0;
      put(HDR); gap($urandom_range(maxgap));
      put(8'(n >> 8)); gap($urandom_range(maxgap));
      put(8'(n)); gap($urandom_range(maxgap));
      for (int i = 0; i < 4 * n; i++) begin
         b = 8'($urandom); acc ^= b;
         put(b); gap($urandom_range(maxgap));
      end
      put(bad ? acc ^ 8'(1 + $urandom_range(254)) : acc);
      gap(2);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk); #2; reset = 1'b1; rx_valid = 1'b0;
      gap(n);
      @(posedge clk); #2; reset = 1'b0;
   endtask

   initial begin
      int base;
      logic [7:0] nb;
      gap(3);
      @(negedge clk);
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_wr_addr", wr_addr, 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      @(posedge clk); #2; reset = 1'b0;
      cmp_en = 1'b1;

      // single word, correct checksum
      base = d_wr_cnt;
      put(HDR); put(8'h00); put(8'h01); put(8'h20); put(8'h08); put(8'h00); put(8'h40); put(8'h68);
      gap(2); @(negedge clk);
      chk("v1_writes", 32'(d_wr_cnt - base), 32'd1);
      chk("v1_word", d_ram[0], 32'h20080040);
      chk("v1_done", {31'd0, done}, 32'd1);
      chk("v1_hold", {31'd0, cpu_hold}, 32'd0);

      // two words, bad checksum
      base = d_wr_cnt;
      put(HDR); put(8'h00); put(8'h02);
      put(8'h11); put(8'h22); put(8'h33); put(8'h44);
      put(8'hDE); put(8'hAD); put(8'hBE); put(8'hEF);
      put(8'h00);
      gap(2); @(negedge clk);
      chk("v2_writes", 32'(d_wr_cnt - base), 32'd2);
      chk("v2_w0", d_ram[0], 32'h11223344);
      chk("v2_w1", d_ram[1], 32'hDEADBEEF);
      chk("v2_error", {31'd0, error}, 32'd1);
      chk("v2_hold", {31'd0, cpu_hold}, 32'd1);

      // oversize count, then empty image restarts cleanly
      base = d_wr_cnt;
      put(HDR); put(8'h00); put(8'h81); gap(3); @(negedge clk);
      chk("v3_error", {31'd0, error}, 32'd1);
      chk("v3_writes", 32'(d_wr_cnt - base), 32'd0);
      put(HDR); put(8'h00); put(8'h00); put(8'h00); gap(2); @(negedge clk);
      chk("v5_done", {31'd0, done}, 32'd1);
      chk("v5_hold", {31'd0, cpu_hold}, 32'd0);
      chk("v5_writes", 32'(d_wr_cnt - base), 32'd0);

      // timeout after five word bytes
      base = d_wr_cnt;
      put(HDR); put(8'h00); put(8'h03);
      put(8'h01); put(8'h02); put(8'h03); put(8'h04); put(8'h05);
      gap(TMO + 2); @(negedge clk);
      chk("v4_error", {31'd0, error}, 32'd1);
      chk("v4_writes", 32'(d_wr_cnt - base), 32'd1);
      chk("v4_word", d_ram[0], 32'h01020304);

      // silence one cycle short of the limit is tolerated
      put(HDR); gap(TMO - 1); put(8'h00); gap(TMO - 1); put(8'h00); gap(TMO - 1); put(8'h00);
      gap(2); @(negedge clk);
      chk("tmo_edge_done", {31'd0, done}, 32'd1);

      // reset during WORD
      put(HDR); put(8'h00); put(8'h02); put(8'h12); put(8'h34);
      do_reset(2); @(negedge clk);
      chk("midrst_hold", {31'd0, cpu_hold}, 32'd1);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_data", wr_data, 32'd0);

      // full-depth image, back-to-back bytes
      send_frame(DEPTH, 1'b0, 0);
      @(negedge clk);
      chk("full_done", {31'd0, done}, 32'd1);

      // randomized frames with noise, gaps and corrupted checksums
      for (int f = 0; f < 40; f++) begin
         repeat ($urandom_range(3)) begin
            nb = 8'($urandom); if (nb == HDR) nb = 8'h00;
            put(nb); gap($urandom_range(2));
         end
         if ($urandom_range(9) == 0) send_frame(DEPTH + 1 + $urandom_range(3), 1'b0, 1);
         else send_frame($urandom_range(6), $urandom_range(3) == 0, 3);
      end

      gap(3);
      cmp_en = 1'b0;
      chk("write_count", d_wr_cnt, m_wr_cnt);
      for (int i = 0; i < DEPTH; i++) chk("ram_image", d_ram[i], m_ram[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
